// File: rtl/prefix_pkg.sv
// Shared op codes, FSM state encoding and token field helpers for the expression evaluator.
package prefix_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_OUT
  } state_t;

  // Tokens are passed zero-padded to 32 bits together with their real width.
  function automatic logic tok_is_op(input logic [31:0] tok, input int unsigned tok_w);
    return tok[tok_w-1];
  endfunction

  function automatic logic [31:0] tok_val(input logic [31:0] tok, input int unsigned tok_w);
    return tok & ((32'd1 << (tok_w - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/prefix_rpn_eval_if.sv
// Token-in / result-out bundle between the token source, the evaluator and the result checker.
interface prefix_rpn_eval_if #(
  parameter int TOK_W = 5,
  parameter int OUT_W = 95
);
  logic                    in_valid;
  logic                    opt;
  logic [TOK_W-1:0]        in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out;
  logic                    err;

  modport master (output in_valid, opt, in_data, input out_valid, out, err);
  modport slave  (input in_valid, opt, in_data, output out_valid, out, err);
endinterface

// File: rtl/prefix_alu.sv
// Combinational ALU: o_res = i_x OP i_y, wrapping in ACC_W bits; division truncates toward zero.
module prefix_alu
  import prefix_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] i_x,
  input  logic signed [ACC_W-1:0] i_y,
  input  logic [1:0]              i_op,
  output logic signed [ACC_W-1:0] o_res,
  output logic                    o_div_zero
);

  always_comb begin
    o_res      = '0;
    o_div_zero = 1'b0;
    case (i_op)
      OP_ADD: o_res = i_x + i_y;
      OP_SUB: o_res = i_x - i_y;
      OP_MUL: o_res = i_x * i_y;
      default: begin
        // Divide by -1 is negation so the most-negative value wraps onto itself.
        if (i_y == '0)      o_div_zero = 1'b1;
        else if (i_y == '1) o_res = -i_x;
        else                o_res = i_x / i_y;
      end
    endcase
  end

endmodule

// File: rtl/prefix_rpn_eval.sv
// Buffers one token frame, then evaluates it prefix (last->first) or postfix (first->last) on an
// operand stack, one token per cycle; result strobes L+2 cycles after the last token.
module prefix_rpn_eval
  import prefix_pkg::*;
#(
  parameter int N_TOK = 19,
  parameter int TOK_W = 5,
  parameter int ACC_W = 40,
  parameter int OUT_W = 95,
  parameter int STK_D = (N_TOK + 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  prefix_rpn_eval_if.slave bus
);

  localparam int CNT_W = $clog2(N_TOK + 1);
  localparam int SP_W  = $clog2(STK_D + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_TOK);
  localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(STK_D);

  state_t                  r_state;
  logic                    r_opt;
  logic                    r_err;
  logic                    r_out_valid;
  logic                    r_out_err;
  logic signed [OUT_W-1:0] r_out;
  logic [TOK_W-1:0]        r_buf [N_TOK];
  logic signed [ACC_W-1:0] r_stk [STK_D];
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        r_cnt;
  logic [SP_W-1:0]         r_sp;

  logic [CNT_W-1:0]        w_idx;
  logic [TOK_W-1:0]        w_tok;
  logic                    w_is_op;
  logic signed [ACC_W-1:0] w_opnd;
  logic signed [ACC_W-1:0] w_top;
  logic signed [ACC_W-1:0] w_nxt;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_y;
  logic signed [ACC_W-1:0] w_res;
  logic                    w_div_zero;

  assign w_idx   = r_opt ? r_cnt : (r_len - r_cnt - CNT_W'(1));
  assign w_tok   = r_buf[w_idx];
  assign w_is_op = tok_is_op(32'(w_tok), TOK_W);
  assign w_opnd  = ACC_W'(tok_val(32'(w_tok), TOK_W));
  assign w_top   = r_stk[r_sp - SP_W'(1)];
  assign w_nxt   = r_stk[r_sp - SP_W'(2)];
  // Prefix computes top OP next, postfix computes next OP top.
  assign w_x     = r_opt ? w_nxt : w_top;
  assign w_y     = r_opt ? w_top : w_nxt;

  prefix_alu #(.ACC_W(ACC_W)) u_alu (
    .i_x        (w_x),
    .i_y        (w_y),
    .i_op       (w_tok[1:0]),
    .o_res      (w_res),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_opt       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sp        <= '0;
      for (int i = 0; i < N_TOK; i++) r_buf[i] <= '0;
      for (int i = 0; i < STK_D; i++) r_stk[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out       <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_buf[0] <= bus.in_data;
            r_len    <= CNT_W'(1);
            r_opt    <= bus.opt;
            r_err    <= 1'b0;
            r_sp     <= '0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            if (r_len == CNT_MAX) begin
              r_err <= 1'b1;
            end else begin
              r_buf[r_len] <= bus.in_data;
              r_len        <= r_len + CNT_W'(1);
            end
          end else begin
            r_cnt   <= '0;
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // Faulty tokens only flag the error; the scan length is never shortened.
          if (w_is_op) begin
            if (r_sp < SP_W'(2)) begin
              r_err <= 1'b1;
            end else begin
              r_stk[r_sp - SP_W'(2)] <= w_res;
              r_sp                   <= r_sp - SP_W'(1);
              if (w_div_zero) r_err <= 1'b1;
            end
          end else if (r_sp == SP_MAX) begin
            r_err <= 1'b1;
          end else begin
            r_stk[r_sp] <= w_opnd;
            r_sp        <= r_sp + SP_W'(1);
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == r_len - CNT_W'(1)) r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_out_valid <= 1'b1;
          if (r_err || r_sp != SP_W'(1)) r_out_err <= 1'b1;
          else                           r_out     <= OUT_W'(r_stk[0]);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.err       = r_out_err;

endmodule
